// File: rtl/exu_mul_wb_pkg.sv
// Shared types for the multiply writeback controller: queue packet, stage tag and default sizes.
package exu_mul_wb_pkg;

    localparam int MUL_WBQ_DEPTH = 4;
    localparam int MUL_RD_W      = 5;

    typedef struct packed {
        logic [MUL_RD_W-1:0] rd;
        logic [31:0]         data;
    } mul_wb_pkt_t;

    typedef struct packed {
        logic                valid;
        logic [MUL_RD_W-1:0] rd;
    } mul_tag_t;

    localparam int MUL_PKT_W = $bits(mul_wb_pkt_t);

endpackage

// File: rtl/exu_mul_wbq.sv
// Writeback queue: FIFO of finished multiply results with occupancy and a raw entry view.
// Latency: a push is visible at the head one cycle later; no push-to-pop bypass.
// Backpressure: no ready of its own; the producer must never push into a full queue.
module exu_mul_wbq #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic                           push_i,
    input  logic [W-1:0]                   push_dat_i,
    input  logic                           pop_i,
    output logic [W-1:0]                   head_dat_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH)-1:0]       head_ptr_o,
    output logic [DEPTH-1:0][W-1:0]        ent_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    push_ok;
    logic                    pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Power-of-two depth, so the pointer increment wraps on its own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign head_ptr_o = rd_ptr_q;
    assign ent_o      = mem_q;

endmodule

// File: rtl/exu_mul_wb_ctl.sv
// Multiply writeback control: E1-E3 tag pipe, writeback queue, issue credits, RAW stall and forwarding.
// Latency: issue -> E1/E2/E3 -> queue; wb_valid 4 cycles after issue with no freeze.
// Backpressure: wb head held until wb_grant; issue credit covers queue plus in-flight entries.
module exu_mul_wb_ctl
    import exu_mul_wb_pkg::*;
#(
    parameter int WBQ_DEPTH = MUL_WBQ_DEPTH,
    parameter int RD_W      = MUL_RD_W
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         freeze,
    input  logic                         mul_valid_d,
    input  logic [RD_W-1:0]              mul_rd_d,
    output logic                         mul_ready_d,
    input  logic                         flush_e1,
    input  logic                         flush_e2,
    input  logic                         flush_e3,
    input  logic [31:0]                  mul_out_e3,
    input  logic [RD_W-1:0]              rs1_addr_d,
    input  logic [RD_W-1:0]              rs2_addr_d,
    output logic                         rs1_stall_d,
    output logic                         rs2_stall_d,
    output logic                         rs1_byp_d,
    output logic                         rs2_byp_d,
    output logic [31:0]                  rs1_byp_data_d,
    output logic [31:0]                  rs2_byp_data_d,
    output logic                         wb_valid,
    output logic [RD_W-1:0]              wb_rd,
    output logic [31:0]                  wb_data,
    input  logic                         wb_grant,
    output logic [$clog2(WBQ_DEPTH):0]   wbq_count
);

    localparam int PW = $clog2(WBQ_DEPTH);
    localparam int CW = $clog2(WBQ_DEPTH) + 1;

    mul_tag_t tag_e1_q, tag_e1_d;
    mul_tag_t tag_e2_q, tag_e2_d;
    mul_tag_t tag_e3_q, tag_e3_d;

    // A flush during freeze still kills its own stage; otherwise the stages only move when unfrozen.
    always_comb begin
        tag_e1_d = tag_e1_q;
        tag_e2_d = tag_e2_q;
        tag_e3_d = tag_e3_q;
        if (!freeze) begin
            tag_e1_d.valid = mul_valid_d & mul_ready_d & ~flush_e1;
            tag_e1_d.rd    = mul_rd_d;
            tag_e2_d.valid = tag_e1_q.valid & ~flush_e1;
            tag_e2_d.rd    = tag_e1_q.rd;
            tag_e3_d.valid = tag_e2_q.valid & ~flush_e2;
            tag_e3_d.rd    = tag_e2_q.rd;
        end else begin
            if (flush_e1) tag_e1_d.valid = 1'b0;
            if (flush_e2) tag_e2_d.valid = 1'b0;
            if (flush_e3) tag_e3_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tag_e1_q <= '0;
            tag_e2_q <= '0;
            tag_e3_q <= '0;
        end else begin
            tag_e1_q <= tag_e1_d;
            tag_e2_q <= tag_e2_d;
            tag_e3_q <= tag_e3_d;
        end
    end

    logic                                e3_live;
    logic                                wbq_push;
    logic                                wbq_pop;
    logic                                wbq_full;
    logic                                wbq_empty;
    logic [PW-1:0]                       wbq_head_ptr;
    mul_wb_pkt_t                         push_pkt;
    mul_wb_pkt_t                         head_pkt;
    mul_wb_pkt_t [WBQ_DEPTH-1:0]         wbq_ent;

    assign e3_live  = tag_e3_q.valid & ~flush_e3;
    assign wbq_push = e3_live & ~freeze;
    assign push_pkt = '{rd: tag_e3_q.rd, data: mul_out_e3};
    assign wbq_pop  = wb_valid & wb_grant;

    exu_mul_wbq #(
        .DEPTH (WBQ_DEPTH),
        .W     (MUL_PKT_W)
    ) u_wbq (
        .clk        (clk),
        .rst_l      (rst_l),
        .push_i     (wbq_push),
        .push_dat_i (push_pkt),
        .pop_i      (wbq_pop),
        .head_dat_o (head_pkt),
        .count_o    (wbq_count),
        .full_o     (wbq_full),
        .empty_o    (wbq_empty),
        .head_ptr_o (wbq_head_ptr),
        .ent_o      (wbq_ent)
    );

    assign wb_valid = ~wbq_empty;
    assign wb_rd    = wb_valid ? head_pkt.rd   : '0;
    assign wb_data  = wb_valid ? head_pkt.data : '0;

    // Credits count every in-flight stage so an E3 push always finds room.
    logic [CW:0] credit_use;
    assign credit_use  = {1'b0, wbq_count} + (CW+1)'(tag_e1_q.valid)
                       + (CW+1)'(tag_e2_q.valid) + (CW+1)'(tag_e3_q.valid);
    assign mul_ready_d = credit_use < (CW+1)'(WBQ_DEPTH);

    logic [1:0][RD_W-1:0] rs_addr;
    logic [1:0]           stall_v;
    logic [1:0]           hit_v;
    logic [1:0][31:0]     dat_v;
    logic [PW-1:0]        idx;

    assign rs_addr = {rs2_addr_d, rs1_addr_d};

    // Scan queue oldest to youngest so later hits override, then let E3 override the queue.
    always_comb begin
        stall_v = '0;
        hit_v   = '0;
        dat_v   = '0;
        idx     = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < WBQ_DEPTH; i++) begin
                idx = wbq_head_ptr + PW'(i);
                if ((CW'(i) < wbq_count) && (wbq_ent[idx].rd == rs_addr[s])) begin
                    hit_v[s] = 1'b1;
                    dat_v[s] = wbq_ent[idx].data;
                end
            end
            if (e3_live && (tag_e3_q.rd == rs_addr[s])) begin
                hit_v[s] = 1'b1;
                dat_v[s] = mul_out_e3;
            end
            stall_v[s] = (tag_e1_q.valid && (tag_e1_q.rd == rs_addr[s])) ||
                         (tag_e2_q.valid && (tag_e2_q.rd == rs_addr[s]));
            if (rs_addr[s] == '0) begin
                hit_v[s]   = 1'b0;
                dat_v[s]   = '0;
                stall_v[s] = 1'b0;
            end
        end
    end

    assign rs1_stall_d    = stall_v[0];
    assign rs2_stall_d    = stall_v[1];
    assign rs1_byp_d      = hit_v[0];
    assign rs2_byp_d      = hit_v[1];
    assign rs1_byp_data_d = dat_v[0];
    assign rs2_byp_data_d = dat_v[1];

    wbq_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_l) !(wbq_push && wbq_full));

endmodule
